// File: rtl/seg_pkg.sv
// Purpose: shared constants, segment table and scan FSM states for the 7-segment scan decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

    // All segments off on an active-low bus.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HELD    = 2'd2
    } scan_state_t;

    // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Purpose: frame delivery bundle (data, blank flags, valid/ready) from the scan decoder.
// Latency: n/a (wiring only).
// Backpressure: frame_ready from the consumer; producer holds the frame while valid & !ready.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] frame_data;
    logic [NUM_DIGITS-1:0]   frame_blank;
    logic                    frame_valid;
    logic                    frame_ready;

    modport master (
        output frame_data,
        output frame_blank,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_blank,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Purpose: map an active-low 7-segment pattern to {hit, blank, value}.
// Latency: combinational.
// Backpressure: none.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] value
);

    // Table search; blank never matches a digit so its value stays 0.
    always_comb begin
        hit   = 1'b0;
        value = 4'h0;
        blank = (pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (!hit && (hex_to_seg(4'(i)) == pattern)) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Purpose: recover hex digits from a multiplexed common-anode display bus and emit one frame per full scan.
// Latency: 2 sync cycles + STABLE_CYCLES to accept a digit; frame_valid 2 cycles after the last digit accept.
// Backpressure: frame held while valid & !ready; a frame completing then is dropped with an overflow pulse.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n_in,
    input  logic [NUM_DIGITS-1:0] an_n_in,
    seg_scan_decoder_if.master    frm,
    output logic                  pattern_err,
    output logic                  overflow
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam int SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(STABLE_CYCLES);

    logic [6:0]            seg_s1, seg_s2, lat_seg, lat_seg_nxt;
    logic [NUM_DIGITS-1:0] an_s1, an_s2, lat_an, lat_an_nxt, an_act;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    scan_state_t           state, state_nxt;
    logic                  slot_valid, same_pair, accept;
    logic [SLOT_W-1:0]     acc_slot;
    logic                  dec_hit, dec_blank;
    logic [3:0]            dec_val;
    logic [4*NUM_DIGITS-1:0] stage_data;
    logic [NUM_DIGITS-1:0] stage_blank, mask, mask_set;
    logic                  frame_done, stage_wr;

    // Two-flop synchronizers; idle bus (all ones) out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_n_in;
            an_s2  <= an_s1;
        end
    end

    // Exactly one anode low marks a usable slot; compare against the latched pair.
    always_comb begin
        an_act     = ~an_s2;
        slot_valid = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
        same_pair  = (seg_s2 == lat_seg) && (an_s2 == lat_an);
    end

    // Scan FSM state, stability counter and latched (slot, pattern) pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_seg <= '1;
            lat_an  <= '1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lat_seg <= lat_seg_nxt;
            lat_an  <= lat_an_nxt;
        end
    end

    // Next state: qualify a pair for STABLE_CYCLES samples, accept once, then hold until it changes.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_seg_nxt = lat_seg;
        lat_an_nxt  = lat_an;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (slot_valid) begin
                    state_nxt   = QUALIFY;
                    cnt_nxt     = CNT_ONE;
                    lat_seg_nxt = seg_s2;
                    lat_an_nxt  = an_s2;
                end
            end
            QUALIFY: begin
                if (same_pair) begin
                    cnt_nxt = cnt + CNT_ONE;
                    if ((cnt + CNT_ONE) == CNT_DONE) begin
                        accept    = 1'b1;
                        state_nxt = HELD;
                    end
                end else begin
                    cnt_nxt     = CNT_ONE;
                    lat_seg_nxt = seg_s2;
                    lat_an_nxt  = an_s2;
                    state_nxt   = slot_valid ? QUALIFY : IDLE;
                end
            end
            HELD: begin
                if (!same_pair) begin
                    cnt_nxt     = CNT_ONE;
                    lat_seg_nxt = seg_s2;
                    lat_an_nxt  = an_s2;
                    state_nxt   = slot_valid ? QUALIFY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    seg_pattern_decode u_decode (
        .pattern (lat_seg),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .value   (dec_val)
    );

    // Slot index of the accepted digit and the mask bit it contributes.
    always_comb begin
        acc_slot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!lat_an[i]) acc_slot = SLOT_W'(i);
        end
        stage_wr           = accept && (dec_hit || dec_blank);
        mask_set           = '0;
        mask_set[acc_slot] = stage_wr;
        frame_done         = &mask;
    end

    // Staging: latest accepted value per digit; mask clears the cycle after it fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data  <= '0;
            stage_blank <= '0;
            mask        <= '0;
        end else begin
            mask <= (frame_done ? '0 : mask) | mask_set;
            if (stage_wr) begin
                stage_data[4*acc_slot +: 4] <= dec_val;
                stage_blank[acc_slot]       <= dec_blank;
            end
        end
    end

    // Output frame register with valid/ready hold, plus error and overflow pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm.frame_data  <= '0;
            frm.frame_blank <= '0;
            frm.frame_valid <= 1'b0;
            pattern_err     <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            pattern_err <= accept && !dec_hit && !dec_blank;
            overflow    <= 1'b0;
            if (frame_done) begin
                if (!frm.frame_valid || frm.frame_ready) begin
                    frm.frame_data  <= stage_data;
                    frm.frame_blank <= stage_blank;
                    frm.frame_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (frm.frame_valid && frm.frame_ready) begin
                frm.frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the segment encoder. Monitors a time-multiplexed, common-anode 7-segment display bus (active-low segments and active-low anode selects) and recovers the displayed hex digits. It qualifies each anode slot for stability, decodes the segment pattern and assembles one frame per full scan. Frames are delivered over a valid/ready interface to scoreboards, self-checking display monitors or a loopback test path.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode lines)
STABLE_CYCLES, 16, consecutive identical synchronized samples required to accept a digit (>=2)
CNT_WIDTH, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
seg_n_in  input  7  segment lines {g,f,e,d,c,b,a}, active-low, asynchronous to clk
an_n_in  input  NUM_DIGITS  anode selects, active-low, one-hot-low when driven; asynchronous
frame_data  output  4*NUM_DIGITS  decoded digits; digit i at [4i+3:4i]
frame_blank  output  NUM_DIGITS  bit i set = digit i was blank (all segments off)
frame_valid  output  1  frame available
frame_ready  input  1  consumer accepts frame when frame_valid & frame_ready
pattern_err  output  1  one-cycle pulse: stable non-blank pattern not in decode table
overflow  output  1  one-cycle pulse: completed frame dropped because output still held

Behaviour:
- Reset: frame_data=0, frame_blank=0, frame_valid=0, pattern_err=0, overflow=0; sync flops=all ones (bus idle); capture mask cleared; FSM=IDLE.
- Input path: 2-flop synchronizer on seg_n_in and an_n_in; all logic uses synchronized values.
- Slot validity: exactly one bit of an_n low = valid slot i; none or more than one low = invalid.
- FSM IDLE: wait for valid slot; on valid -> QUALIFY, counter=1, latch (slot, pattern).
- QUALIFY: each cycle the (slot, pattern) pair equals the latched pair -> counter+1; on any difference -> relatch and counter=1 (stay in QUALIFY if still valid, else IDLE). When counter reaches STABLE_CYCLES -> accept digit, go to HELD.
- HELD: digit already accepted; ignore until the pair changes; change -> QUALIFY (valid) or IDLE (invalid). Prevents re-accepting the same slot while static.
- Accept: pattern decoded via package table (0-9, A, b, C, d, E, F). Blank (7'b1111111) -> value 0, blank bit set, mask bit set. Unknown pattern -> pattern_err pulse on the accept cycle, mask bit not set, staging unchanged.
- Staging: per-digit value+blank register; re-accepting a digit before the frame completes overwrites it (latest wins).
- Frame complete: the cycle the mask becomes all ones. The next cycle, mask clears, and:
  - output empty, or frame_valid&frame_ready in that cycle -> load frame_data/frame_blank, frame_valid=1;
  - otherwise -> overflow pulse, frame dropped, held output untouched.
- frame_valid drops the cycle after handshake unless a new frame loads the same cycle. Outputs stable while valid & !ready.
- Latency: pin change -> 2 sync cycles + STABLE_CYCLES -> accept; +1 cycle -> frame_valid.
- rst mid-operation: immediate return to reset state; partially assembled and pending frames discarded, no pulses emitted.

Decomposition:
- Package seg_pkg: SEG_BLANK constant, 16-entry hex-to-segment constant table (0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110), FSM state encoding (IDLE, QUALIFY, HELD).
- One sub-module: seg_pattern_decode (combinational, 7-bit pattern -> {hit, blank, value[3:0]}), reused by bench scoreboards.

Test Plan:
- Scan digits 3,0,A,F (slots 0..3), each slot held 40 cycles -> one frame_valid, frame_data=16'hFA03, frame_blank=0, no pulses.
- Slot 2 blank, others 1,2,4 -> frame_data=16'h4021, frame_blank=4'b0100.
- Slot 1 glitches to 8 for 5 cycles then 7 for 40 cycles (STABLE_CYCLES=16) -> digit 1 decoded as 7, never 8.
- Slot 0 shows 7'b1010101 for 40 cycles -> exactly one pattern_err pulse, no frame until a valid digit 0 is scanned.
- frame_ready held low across two complete scans -> first frame held unchanged, one overflow pulse on the second; ready=1 -> handshake, frame_valid=0 next cycle.
- an_n_in=4'b0000 (multiple active) for 50 cycles -> no accepts; assert rst mid-scan -> all outputs 0 next cycle, following full scan produces a correct frame.
